// File: rtl/rr_mux8_if.sv
// Handshake bundle between eight producer channels, the round-robin
// collector and its single downstream consumer.
interface rr_mux8_if #(
    parameter int WIDTH = 8
);
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_ready;

    // Environment side: producers plus the downstream consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Collector side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux8.sv
// Eight-to-one round-robin collector: grants one valid channel per cycle,
// starting the search at ptr, into a single registered output stage.
module rr_mux8 #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    rr_mux8_if.slave   bus
);
    logic [WIDTH-1:0] ch_data [8];
    logic [2:0]       idx_w   [8];
    logic [7:0]       req_rot;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [2:0]       out_sel_q,   out_sel_d;
    logic [2:0]       ptr_q,       ptr_d;

    logic             load;
    logic             found;
    logic [2:0]       offset;
    logic [2:0]       grant_idx;
    logic             grant_en;

    // req_rot[k] is the request of the channel k places behind ptr,
    // so the lowest set bit is the winner.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chan
            assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
            assign idx_w[gi]   = ptr_q + 3'(gi);
            assign req_rot[gi] = bus.in_valid[idx_w[gi]];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                offset = 3'(k);
            end
        end
    end

    assign load      = !out_valid_q || bus.out_ready;
    assign grant_idx = ptr_q + offset;
    assign grant_en  = load && found && !rst;

    assign bus.in_ready = grant_en ? (8'b1 << grant_idx) : 8'b0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = ch_data[grant_idx];
                out_sel_d   = grant_idx;
                ptr_d       = grant_idx + 3'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 3'd0;
            ptr_q       <= 3'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux8.sv
// Bench for rr_mux8: directed vector table with hand-derived expectations,
// then randomized traffic against a priority-distance reference model.
module tb_rr_mux8;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_mux8_if #(.WIDTH(WIDTH)) bus ();

    rr_mux8 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] base;
        logic [7:0] exp_rdy;
        logic       exp_v;
        logic [2:0] exp_sel;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
    } word_t;

    vec_t  tbl[$];
    word_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference state: the output register contents and the priority pointer.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic [2:0] m_sel   = 3'd0;
    int         m_ptr   = 0;

    logic [7:0] obs_rdy;
    logic       obs_v;
    logic [2:0] obs_sel;
    logic [7:0] obs_data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Winner is the valid channel with the smallest forward distance from ptr.
    function automatic int ref_grant(input logic [7:0] iv, input int ptr);
        int best  = -1;
        int bestd = 8;
        for (int ch = 0; ch < 8; ch++) begin
            int d = (ch - ptr + 8) % 8;
            if (iv[ch] && d < bestd) begin
                bestd = d;
                best  = ch;
            end
        end
        return best;
    endfunction

    function automatic logic [63:0] pattern(input logic [7:0] base);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = base + 8'(i);
        return d;
    endfunction

    task automatic step(input string tag, input logic r, input logic [7:0] iv,
                        input logic [63:0] d, input logic o);
        int         g;
        logic       ld;
        logic [7:0] e_rdy;
        word_t      w;
        @(negedge clk);
        rst = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = o;
        #1;
        g     = ref_grant(iv, m_ptr);
        ld    = !m_valid || o;
        e_rdy = (!r && ld && g >= 0) ? (8'b1 << g) : 8'b0;
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(e_rdy));
        obs_rdy = bus.in_ready;
        if (!r && m_valid && o) begin
            if (sb.size() == 0) begin
                chk({tag, " drain_without_word"}, 64'(1), 64'(0));
            end else begin
                w = sb.pop_front();
                chk({tag, " drain_sel"},  64'(bus.out_sel),  64'(w.sel));
                chk({tag, " drain_data"}, 64'(bus.out_data), 64'(w.data));
            end
        end
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_data = 8'h00; m_sel = 3'd0; m_ptr = 0;
            sb.delete();
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d[g*8 +: 8];
                m_sel   = 3'(g);
                m_ptr   = (g + 1) % 8;
                sb.push_back('{sel: 3'(g), data: d[g*8 +: 8]});
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(m_valid));
        chk({tag, " out_sel"},   64'(bus.out_sel),   64'(m_sel));
        chk({tag, " out_data"},  64'(bus.out_data),  64'(m_data));
        obs_v = bus.out_valid; obs_sel = bus.out_sel; obs_data = bus.out_data;
    endtask

    task automatic add(input logic r, input logic [7:0] iv, input logic o, input logic [7:0] base,
                       input logic [7:0] er, input logic ev, input logic [2:0] es, input logic [7:0] ed);
        tbl.push_back('{rst: r, iv: iv, ordy: o, base: base,
                        exp_rdy: er, exp_v: ev, exp_sel: es, exp_data: ed});
    endtask

    initial begin
        bus.in_valid  = 8'h00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held two cycles with arbitrary inputs.
        add(1, 8'hFF, 0, 8'h10, 8'h00, 0, 3'd0, 8'h00);
        add(1, 8'hAA, 1, 8'h10, 8'h00, 0, 3'd0, 8'h00);
        // Full rotation, ten cycles.
        for (int i = 0; i < 10; i++)
            add(0, 8'hFF, 1, 8'h10, 8'b1 << (i % 8), 1, 3'(i % 8), 8'h10 + 8'(i % 8));
        // Sparse requests from ptr=0: 2, 6, 2; then lone channel 5 wrapping from ptr=6.
        add(1, 8'h00, 1, 8'h00, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h44, 1, 8'h20, 8'h04, 1, 3'd2, 8'h22);
        add(0, 8'h44, 1, 8'h20, 8'h40, 1, 3'd6, 8'h26);
        add(0, 8'h44, 1, 8'h20, 8'h04, 1, 3'd2, 8'h22);
        add(0, 8'h20, 1, 8'h20, 8'h20, 1, 3'd5, 8'h25);
        add(0, 8'h20, 1, 8'h30, 8'h20, 1, 3'd5, 8'h35);
        // Backpressure: channel 3 carries A5, held four cycles, then channel 4.
        add(0, 8'h08, 1, 8'hA2, 8'h08, 1, 3'd3, 8'hA5);
        for (int i = 0; i < 4; i++)
            add(0, 8'hFF, 0, 8'h50, 8'h00, 1, 3'd3, 8'hA5);
        add(0, 8'hFF, 1, 8'h50, 8'h10, 1, 3'd4, 8'h54);
        // Idle drain after one word from channel 1; ptr must remain 2.
        add(0, 8'h02, 1, 8'h60, 8'h02, 1, 3'd1, 8'h61);
        add(0, 8'h00, 1, 8'h60, 8'h00, 0, 3'd1, 8'h61);
        add(0, 8'h00, 1, 8'h60, 8'h00, 0, 3'd1, 8'h61);
        add(0, 8'hFF, 1, 8'h70, 8'h04, 1, 3'd2, 8'h72);
        // Reset while channel 5's word is held under backpressure.
        add(0, 8'h20, 1, 8'h80, 8'h20, 1, 3'd5, 8'h85);
        add(1, 8'hFF, 0, 8'h80, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'hFF, 1, 8'h90, 8'h01, 1, 3'd0, 8'h90);
        add(0, 8'h00, 1, 8'h90, 8'h00, 0, 3'd0, 8'h90);

        foreach (tbl[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            step(tag, tbl[k].rst, tbl[k].iv, pattern(tbl[k].base), tbl[k].ordy);
            chk({tag, " tbl_in_ready"},  64'(obs_rdy),  64'(tbl[k].exp_rdy));
            chk({tag, " tbl_out_valid"}, 64'(obs_v),    64'(tbl[k].exp_v));
            chk({tag, " tbl_out_sel"},   64'(obs_sel),  64'(tbl[k].exp_sel));
            chk({tag, " tbl_out_data"},  64'(obs_data), 64'(tbl[k].exp_data));
            $display("vec %0d rst=%0b in_valid=%h out_ready=%0b in_ready=%h out_valid=%0b sel=%0d data=%h",
                     k, tbl[k].rst, tbl[k].iv, tbl[k].ordy, obs_rdy, obs_v, obs_sel, obs_data);
        end

        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic [7:0] iv;
            logic       o;
            r  = ($urandom_range(0, 63) == 0);
            iv = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            o  = ($urandom_range(0, 3) != 0);
            step($sformatf("rnd%0d", n), r, iv, {$urandom, $urandom}, o);
            $display("rnd %0d rst=%0b in_valid=%h out_ready=%0b in_ready=%h out_valid=%0b sel=%0d data=%h",
                     n, r, iv, o, obs_rdy, obs_v, obs_sel, obs_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_mux8.md
# rr_mux8

Eight-to-one round-robin collecting multiplexer, the gathering counterpart of the demux tree. Eight producer channels each present a data word with a valid/ready handshake. The block picks one ready word per cycle using a rotating priority and registers it into a single output stage. Each output word carries the 3-bit channel index, so a downstream demux8 can route it back by index.

## Interface
- WIDTH, default 8: data word width per channel.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  8  bit i set: channel i presents a word.
- in_data  input  8*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  8  one-hot or zero; bit i set means channel i's word is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_sel  output  3  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word this cycle.

## Operation
- State: output register (out_valid, out_data, out_sel) and a 3-bit priority pointer ptr.
- ptr marks the highest-priority channel. Priority order is ptr, ptr+1, …, ptr+7, all mod 8, wrapping 7→0.
- load = !out_valid | out_ready. The register can accept a word when it is empty or is being drained this same cycle.
- Grant: when load=1, grant the first channel in priority order whose in_valid=1.
  - in_ready = one-hot grant vector.
  - in_ready = 0 when load=0 or no in_valid bit is set.
- in_ready is combinational from in_valid, out_valid, out_ready and ptr. Producers must not make in_valid depend on in_ready.
- On a grant to channel g at the clock edge:
  - out_data ← in_data[g]
  - out_sel ← g
  - out_valid ← 1
  - ptr ← g+1 mod 8
- On load=1 with no grant: out_valid ← 0. out_data and out_sel keep their previous values (don't-care).
- When load=0 (out_valid=1 and out_ready=0), out_valid, out_data and out_sel hold stable.
- ptr changes only on a grant.
- No word is dropped or duplicated. Each accepted word appears on the output exactly once, in acceptance order.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0 (channel 0 highest priority). With out_valid=0 after reset, in_ready follows the grant logic.
- Reset mid-operation: any held output word is discarded. Everything returns to reset values on the edge where rst=1. rst overrides any grant in that cycle, and in_ready is forced to 0 while rst=1.
- Latency: a word accepted at edge N is presented on out_* from edge N until the edge where out_ready=1.
- Throughput: one word per cycle when out_ready stays 1, because drain and load happen in the same cycle.
- Backpressure: while out_valid=1 and out_ready=0, every bit of in_ready is 0.
- Fairness: with all eight channels continuously valid and out_ready=1, grants rotate 0,1,2,…,7,0,… One channel waits at most 7 grants to other channels.
- Simultaneous requests are resolved only by ptr. The index value itself carries no fixed priority beyond ptr.

## Test plan
- Reset: hold rst=1 for 2 cycles with arbitrary inputs → out_valid=0, out_data=0, out_sel=0, in_ready=0; after release, the first grant with all channels valid goes to channel 0.
- Full rotation: all in_valid=8'hFF, in_data[i]=8'h10+i, out_ready=1 for 10 cycles → out_sel sequence 0,1,…,7,0,1; out_data sequence 10,11,…,17,10,11; in_ready one-hot every cycle.
- Sparse requests: only channels 2 and 6 valid, ptr=0 → grant 2, then 6, then 2; with only channel 5 valid and ptr=6, the grant wraps to 5 and ptr becomes 6.
- Backpressure: grant channel 3 (data 8'hA5), then out_ready=0 for 4 cycles with all valid → out_valid=1, out_data=8'hA5, out_sel=3 held; in_ready=0. When out_ready returns to 1, channel 4 is granted in that same cycle.
- Idle drain: single word from channel 1, then in_valid=0 and out_ready=1 → out_valid falls the cycle after the word is consumed; ptr stays 2.
- Reset mid-stream: rst=1 while out_valid=1, out_sel=5 and out_ready=0 → next cycle out_valid=0 and ptr=0; the held word never appears on the output.
